// File: rtl/control_types_pkg.sv
// Shared execute-stage control types: the multiply/divide operation select and
// small decode helpers used by muldiv_unit.
package control_types_pkg;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } muldiv_op_t;

   function automatic logic md_is_div(input muldiv_op_t op);
      return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
   endfunction

   function automatic logic md_is_rem(input muldiv_op_t op);
      return op inside {MD_REM, MD_REMU};
   endfunction

   function automatic logic md_a_signed(input muldiv_op_t op);
      return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
   endfunction

   function automatic logic md_b_signed(input muldiv_op_t op);
      return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
   endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One multiply (shift-add) or restoring-divide (shift-subtract) iteration on
// a 2*XLEN accumulator; purely combinational.
module muldiv_iter_step #(
   parameter int XLEN = 32
) (
   input  logic              mode_div_i,
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   opnd_i,
   output logic [2*XLEN-1:0] acc_o
);

   logic [XLEN:0] sum_s;
   logic [XLEN:0] rem_sh_s;
   logic [XLEN:0] diff_s;

   // Multiply: add multiplicand into the upper half when the low bit is set,
   // then shift right. Divide: shift left, keep the difference unless it borrows.
   always_comb begin
      sum_s    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
      rem_sh_s = acc_i[2*XLEN-1:XLEN-1];
      diff_s   = rem_sh_s - {1'b0, opnd_i};
      if (mode_div_i) begin
         if (diff_s[XLEN]) begin
            acc_o = {rem_sh_s[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
         end else begin
            acc_o = {diff_s[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
         end
      end else begin
         acc_o = {sum_s, acc_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/REM ops complete as illegal.
module muldiv_unit
   import control_types_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  muldiv_op_t       in_op,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic             out_illegal
);

   localparam int CNT_W = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

   state_t            state_q;
   muldiv_op_t        op_q;
   logic [2*XLEN-1:0] acc_q;
   logic [2*XLEN-1:0] acc_d;
   logic [XLEN-1:0]   opnd_q;
   logic [XLEN-1:0]   result_q;
   logic              neg_q;
   logic              illegal_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              neg_a_s, neg_b_s, neg_res_s;
   logic [XLEN-1:0]   mag_a_s, mag_b_s;
   logic [2*XLEN-1:0] init_acc_s;
   logic [XLEN-1:0]   init_opnd_s;
   logic              special_s, illegal_s;
   logic [XLEN-1:0]   special_res_s;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   qr_s, qr_fix_s, fix_res_s;
   logic              mode_div_s;

   // Operand magnitudes, result sign and accumulator seed for the op being offered.
   always_comb begin
      neg_a_s   = md_a_signed(in_op) & in_a[XLEN-1];
      neg_b_s   = md_b_signed(in_op) & in_b[XLEN-1];
      mag_a_s   = neg_a_s ? (-in_a) : in_a;
      mag_b_s   = neg_b_s ? (-in_b) : in_b;
      neg_res_s = md_is_rem(in_op) ? neg_a_s : (neg_a_s ^ neg_b_s);
      if (md_is_div(in_op)) begin
         init_acc_s  = {{XLEN{1'b0}}, mag_a_s};
         init_opnd_s = mag_b_s;
      end else begin
         init_acc_s  = {{XLEN{1'b0}}, mag_b_s};
         init_opnd_s = mag_a_s;
      end
   end

   // Ops resolved at accept time without iterating.
   always_comb begin
      illegal_s     = 1'b0;
      special_s     = 1'b0;
      special_res_s = {XLEN{1'b0}};
`ifdef MULDIV_DIV_EN
      if (md_is_div(in_op)) begin
         if (in_b == {XLEN{1'b0}}) begin
            special_s     = 1'b1;
            special_res_s = md_is_rem(in_op) ? in_a : {XLEN{1'b1}};
         end else if ((in_op inside {MD_DIV, MD_REM}) && in_a == MIN_INT && in_b == {XLEN{1'b1}}) begin
            special_s     = 1'b1;
            special_res_s = (in_op == MD_REM) ? {XLEN{1'b0}} : MIN_INT;
         end else begin
            special_s     = 1'b0;
         end
      end else begin
         special_s = 1'b0;
      end
`else
      illegal_s = md_is_div(in_op);
      special_s = illegal_s;
`endif
   end

`ifdef MULDIV_DIV_EN
   assign mode_div_s = md_is_div(op_q);
`else
   assign mode_div_s = 1'b0;
`endif

   muldiv_iter_step #(.XLEN(XLEN)) u_step (
      .mode_div_i (mode_div_s),
      .acc_i      (acc_q),
      .opnd_i     (opnd_q),
      .acc_o      (acc_d)
   );

   // Sign application and result selection once iteration is complete.
   always_comb begin
      prod_s   = neg_q ? (-acc_q) : acc_q;
      qr_s     = md_is_rem(op_q) ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
      qr_fix_s = neg_q ? (-qr_s) : qr_s;
      case (op_q)
         MD_MUL:                      fix_res_s = prod_s[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: fix_res_s = prod_s[2*XLEN-1:XLEN];
         default:                     fix_res_s = qr_fix_s;
      endcase
   end

   // Control FSM and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= MD_MUL;
         acc_q     <= {(2*XLEN){1'b0}};
         opnd_q    <= {XLEN{1'b0}};
         result_q  <= {XLEN{1'b0}};
         neg_q     <= 1'b0;
         illegal_q <= 1'b0;
         cnt_q     <= {CNT_W{1'b0}};
      end else if (flush) begin
         state_q <= S_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  op_q      <= in_op;
                  acc_q     <= init_acc_s;
                  opnd_q    <= init_opnd_s;
                  neg_q     <= neg_res_s;
                  illegal_q <= illegal_s;
                  cnt_q     <= {CNT_W{1'b0}};
                  if (special_s) begin
                     result_q <= special_res_s;
                     state_q  <= S_DONE;
                  end else begin
                     state_q  <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(XLEN - 1)) begin
                  state_q <= S_FIXUP;
               end
            end
            S_FIXUP: begin
               result_q <= fix_res_s;
               state_q  <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign out_result  = result_q;
   assign out_illegal = illegal_q;

endmodule
